// File: rtl/muldiv_if.sv
// Handshake and data bundle between the core and the multi-cycle M-extension unit.
// The core side (master) drives the decoded op and operands; the unit (slave)
// returns stall/busy/done and the registered result.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic [5:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output valid, op, rs1, rs2,
    input  stall, busy, done, result
  );

  modport slave (
    input  valid, op, rs1, rs2,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle on
// operand magnitudes, with the sign fix-up applied when the last step retires.
// Divide-by-zero and signed overflow can optionally bypass the iteration.
module muldiv_seq #(
  parameter int XLEN     = 32,
  parameter bit FAST_DIV = 1'b1
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      op_reg;
  logic [XLEN-1:0] a_reg;       // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0] hi_reg;      // product high half or partial remainder
  logic [XLEN-1:0] lo_reg;      // multiplier/product low half or dividend/quotient
  logic [XLEN-1:0] result_reg;
  logic            sign_a_reg, sign_b_reg, div_zero_reg;

  // Incoming op decode: low three bits select the function within the M group.
  logic [2:0]      in_fn;
  logic            is_mop, accept;
  logic            in_is_div, in_is_rem, in_signed_a, in_signed_b;
  logic            rs1_neg, rs2_neg, in_div_zero, in_ovf, in_fast;
  logic [XLEN-1:0] abs1, abs2, fast_result;

  assign in_fn       = bus.op[2:0];
  assign is_mop      = (bus.op[5:3] == 3'b001);
  assign accept      = (state_reg == IDLE) && bus.valid && is_mop;
  assign in_is_div   = (in_fn[2:1] == 2'b00) || (in_fn[2:1] == 2'b11);
  assign in_is_rem   = (in_fn[2:1] == 2'b11);
  assign in_signed_a = (in_fn == 3'b000) || (in_fn == 3'b010) || (in_fn == 3'b011) ||
                       (in_fn == 3'b100) || (in_fn == 3'b110);
  assign in_signed_b = (in_fn == 3'b000) || (in_fn == 3'b010) || (in_fn == 3'b011) ||
                       (in_fn == 3'b110);
  assign rs1_neg     = in_signed_a && bus.rs1[XLEN-1];
  assign rs2_neg     = in_signed_b && bus.rs2[XLEN-1];
  assign abs1        = rs1_neg ? -bus.rs1 : bus.rs1;
  assign abs2        = rs2_neg ? -bus.rs2 : bus.rs2;
  assign in_div_zero = (bus.rs2 == '0);
  // Only div/rem are signed among the divide ops, and they are exactly the ones with signed rs2.
  assign in_ovf      = in_is_div && in_signed_b && (bus.rs1 == MIN_INT) && (bus.rs2 == ALL_ONES);
  assign in_fast     = FAST_DIV && in_is_div && (in_div_zero || in_ovf);
  assign fast_result = in_div_zero ? (in_is_rem ? bus.rs1 : ALL_ONES)
                                   : (in_is_rem ? '0 : MIN_INT);

  // One iteration step for each datapath, computed from the current registers.
  logic            op_is_div, op_is_rem;
  logic [XLEN:0]   mul_sum, div_tmp, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] mul_res, quo_fix, rem_fix, final_result;

  assign op_is_div = (op_reg[2:1] == 2'b00) || (op_reg[2:1] == 2'b11);
  assign op_is_rem = (op_reg[2:1] == 2'b11);
  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
  assign div_tmp   = {hi_reg, lo_reg[XLEN-1]};
  assign div_diff  = div_tmp - {1'b0, a_reg};
  assign div_ge    = (div_tmp >= {1'b0, a_reg});
  assign step_hi   = op_is_div ? (div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0])
                               : mul_sum[XLEN:1];
  assign step_lo   = op_is_div ? {lo_reg[XLEN-2:0], div_ge}
                               : {mul_sum[0], lo_reg[XLEN-1:1]};

  // Sign fix-up; a zero divisor keeps the all-ones quotient regardless of dividend sign.
  assign prod         = {step_hi, step_lo};
  assign prod_fix     = (sign_a_reg ^ sign_b_reg) ? -prod : prod;
  assign mul_res      = (op_reg == 3'b010) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign quo_fix      = ((sign_a_reg ^ sign_b_reg) && !div_zero_reg) ? -step_lo : step_lo;
  assign rem_fix      = sign_a_reg ? -step_hi : step_hi;
  assign final_result = op_is_div ? (op_is_rem ? rem_fix : quo_fix) : mul_res;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and stall decode.
  always_comb begin
    state_next = state_reg;
    bus.stall  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          bus.stall  = 1'b1;
          state_next = in_fast ? DONE : BUSY;
        end
      end
      BUSY: begin
        bus.stall = 1'b1;
        if (cnt_reg == CW'(XLEN-1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;

  // Datapath: latch operands on accept, iterate in BUSY, load result on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      op_reg       <= '0;
      a_reg        <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      result_reg   <= '0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg       <= in_fn;
            sign_a_reg   <= rs1_neg;
            sign_b_reg   <= rs2_neg;
            div_zero_reg <= in_div_zero;
            cnt_reg      <= '0;
            hi_reg       <= '0;
            if (in_is_div) begin
              lo_reg <= abs1;
              a_reg  <= abs2;
            end else begin
              lo_reg <= abs2;
              a_reg  <= abs1;
            end
            if (in_fast) result_reg <= fast_result;
          end
        end
        BUSY: begin
          hi_reg  <= step_hi;
          lo_reg  <= step_lo;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(XLEN-1)) result_reg <= final_result;
        end
        default: ;
      endcase
    end
  end
endmodule
